// File: rtl/dds_ui_pkg.sv
// Shared types and default build constants for the button/mode user-interface block.
package dds_ui_pkg;

    localparam int DEF_NUM_BTN      = 2;
    localparam int DEF_DEBOUNCE_CYC = 50000;
    localparam int DEF_LONG_CYC     = 25000000;
    localparam int DEF_NUM_MODE     = 4;

    typedef enum logic [1:0] {
        BTN_IDLE    = 2'd0,
        BTN_PRESSED = 2'd1,
        BTN_LONG    = 2'd2
    } btn_state_e;

    typedef struct packed {
        logic press;
        logic long_p;
    } btn_evt_t;

endpackage

// File: rtl/btn_mode_ctrl_if.sv
// Button/mode signal bundle. The top keeps flat board-level pin names, so harnesses
// and integrators carry the same signals through this interface.
interface btn_mode_ctrl_if #(
    parameter int NUM_BTN = 2,
    parameter int MODE_W  = 2
);
    logic [NUM_BTN-1:0] btn;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] long_p;
    logic [MODE_W-1:0]  mode;
    logic               mode_chg;

    modport master (output btn, input press, long_p, mode, mode_chg);
    modport slave  (input btn, output press, long_p, mode, mode_chg);
endinterface

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, stable-count debounce, and an
// idle/pressed/long FSM emitting registered one-cycle press and long events.
module btn_debounce
    import dds_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LONG_CYC     = DEF_LONG_CYC
) (
    input  logic     gclk,
    input  logic     grst_n,
    input  logic     btn_raw,
    output btn_evt_t evt
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW = $clog2(LONG_CYC + 1);

    logic [1:0]    sync_q;
    logic          deb_q;
    logic [DW-1:0] db_cnt_q;
    btn_state_e    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    btn_evt_t      evt_q, evt_d;

    // Reset to "released" so a button held through reset must debounce afresh.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            sync_q   <= 2'b11;
            deb_q    <= 1'b1;
            db_cnt_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
            if (sync_q[1] == deb_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
                deb_q    <= sync_q[1];
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            state_q <= BTN_IDLE;
            hold_q  <= '0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            evt_q   <= evt_d;
        end
    end

    // Release is checked before the long threshold; hold_q never passes LONG_CYC.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        evt_d   = '0;
        case (state_q)
            BTN_IDLE: begin
                if (!deb_q) begin
                    state_d = BTN_PRESSED;
                    hold_d  = '0;
                end
            end
            BTN_PRESSED: begin
                if (deb_q) begin
                    state_d     = BTN_IDLE;
                    evt_d.press = 1'b1;
                end else if (hold_q == HW'(LONG_CYC)) begin
                    state_d      = BTN_LONG;
                    evt_d.long_p = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            BTN_LONG: begin
                if (deb_q) state_d = BTN_IDLE;
            end
            default: state_d = BTN_IDLE;
        endcase
    end

    assign evt = evt_q;

endmodule

// File: rtl/btn_mode_ctrl.sv
// Debounced push-button front end plus waveform-mode selector: btn0 steps up,
// btn1 steps down, a btn0 long press returns to mode 0.
module btn_mode_ctrl
    import dds_ui_pkg::*;
#(
    parameter  int NUM_BTN      = DEF_NUM_BTN,
    parameter  int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter  int LONG_CYC     = DEF_LONG_CYC,
    parameter  int NUM_MODE     = DEF_NUM_MODE,
    localparam int MODE_W       = $clog2(NUM_MODE)
) (
    input  logic               Ext_CLK,
    input  logic               Ext_RESETn,
    input  logic [NUM_BTN-1:0] iExtBtn,
    output logic [NUM_BTN-1:0] oPress,
    output logic [NUM_BTN-1:0] oLong,
    output logic [MODE_W-1:0]  oMode,
    output logic               oModeChg
);
    btn_evt_t [NUM_BTN-1:0] evt;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .LONG_CYC    (LONG_CYC)
        ) u_btn (
            .gclk   (Ext_CLK),
            .grst_n (Ext_RESETn),
            .btn_raw(iExtBtn[g]),
            .evt    (evt[g])
        );
        assign oPress[g] = evt[g].press;
        assign oLong[g]  = evt[g].long_p;
    end

    logic              inc, dec, ld;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              chg_q, chg_d;

    assign inc = oPress[0];
    assign dec = oPress[1];
    assign ld  = oLong[0];

    // Long press dominates; opposing steps in the same cycle cancel out.
    always_comb begin
        mode_d = mode_q;
        chg_d  = 1'b0;
        if (ld) begin
            mode_d = '0;
            chg_d  = 1'b1;
        end else if (inc && !dec) begin
            mode_d = (mode_q == MODE_W'(NUM_MODE - 1)) ? '0 : mode_q + 1'b1;
            chg_d  = 1'b1;
        end else if (dec && !inc) begin
            mode_d = (mode_q == '0) ? MODE_W'(NUM_MODE - 1) : mode_q - 1'b1;
            chg_d  = 1'b1;
        end
    end

    always_ff @(posedge Ext_CLK or negedge Ext_RESETn) begin
        if (!Ext_RESETn) begin
            mode_q <= '0;
            chg_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            chg_q  <= chg_d;
        end
    end

    assign oMode    = mode_q;
    assign oModeChg = chg_q;

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// Bench for btn_mode_ctrl: directed scenarios plus random button traffic, each
// cycle compared against a behavioural model of the debounce/press/mode rules.
module tb_btn_mode_ctrl;
    localparam int NB = 3, D = 4, L = 20, NM = 4, MW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    btn_mode_ctrl_if #(.NUM_BTN(NB), .MODE_W(MW)) bus ();

    btn_mode_ctrl #(
        .NUM_BTN(NB), .DEBOUNCE_CYC(D), .LONG_CYC(L), .NUM_MODE(NM)
    ) dut (
        .Ext_CLK   (clk),
        .Ext_RESETn(rst_n),
        .iExtBtn   (bus.btn),
        .oPress    (bus.press),
        .oLong     (bus.long_p),
        .oMode     (bus.mode),
        .oModeChg  (bus.mode_chg)
    );

    int checks = 0, errors = 0, cyc = 0;

    // Reference model state
    logic [NB-1:0] m_s1, m_s2, m_deb, exp_press, exp_long;
    int            exp_mode;
    logic          exp_chg;
    bit            hist[NB][$];
    bit            held[NB];
    int            age[NB];
    bit            long_done[NB];

    logic [NB-1:0] stim[$];
    wire  [8:0]    dut_vec = {bus.press, bus.long_p, bus.mode, bus.mode_chg};

    function automatic logic [8:0] exp_vec();
        return {exp_press, exp_long, MW'(exp_mode), exp_chg};
    endfunction

    task automatic model_reset();
        m_s1 = '1; m_s2 = '1; m_deb = '1;
        exp_press = '0; exp_long = '0; exp_mode = 0; exp_chg = 1'b0;
        for (int b = 0; b < NB; b++) begin
            hist[b].delete();
            held[b] = 1'b0; age[b] = 0; long_done[b] = 1'b0;
        end
    endtask

    // One clock edge: raw -> 2-stage sync -> level accepted after D agreeing
    // samples -> press/long events by hold age -> mode reacts to last edge's events.
    task automatic model_edge(input logic [NB-1:0] raw);
        logic [NB-1:0] np, nl;
        if (exp_long[0]) begin
            exp_mode = 0; exp_chg = 1'b1;
        end else if (exp_press[0] != exp_press[1]) begin
            exp_mode = exp_press[0] ? (exp_mode + 1) % NM : (exp_mode + NM - 1) % NM;
            exp_chg  = 1'b1;
        end else begin
            exp_chg = 1'b0;
        end
        np = '0; nl = '0;
        for (int b = 0; b < NB; b++) begin
            logic s, dprev;
            bit   all_diff;
            s = m_s2[b]; dprev = m_deb[b];
            m_s2[b] = m_s1[b]; m_s1[b] = raw[b];
            hist[b].push_back(s);
            if (hist[b].size() > D) void'(hist[b].pop_front());
            if (hist[b].size() == D) begin
                all_diff = 1'b1;
                for (int i = 0; i < D; i++) if (hist[b][i] == m_deb[b]) all_diff = 1'b0;
                if (all_diff) m_deb[b] = ~m_deb[b];
            end
            if (!held[b]) begin
                if (!dprev) begin held[b] = 1'b1; age[b] = 0; long_done[b] = 1'b0; end
            end else if (dprev) begin
                held[b] = 1'b0;
                if (!long_done[b]) np[b] = 1'b1;
            end else begin
                age[b]++;
                if (age[b] == L + 1) begin nl[b] = 1'b1; long_done[b] = 1'b1; end
            end
        end
        exp_press = np; exp_long = nl;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(bus.btn);
        cyc++;
        #1;
    endtask

    task automatic add(input logic [NB-1:0] v, input int n);
        repeat (n) stim.push_back(v);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (dut_vec !== 9'h0) begin errors++; $display("FAIL reset_hold got=%h exp=000", dut_vec); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== 9'h0) begin errors++; $display("FAIL reset_clocked got=%h exp=000", dut_vec); end
        #4 rst_n = 1'b1;
    endtask

    task automatic test_short();
        int e0 = 0, pc = -100, n0 = 0;
        stim.delete();
        add(3'b111, 5); add(3'b110, 10); add(3'b111, 15);
        foreach (stim[i]) begin
            bus.btn = stim[i]; step();
            if (i == 15) e0 = cyc;
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL short cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); end
            if (bus.press[0]) begin n0++; pc = cyc; end
        end
        checks++; if (n0 != 1) begin errors++; $display("FAIL short_count got=%0d exp=1", n0); end
        checks++; if (pc - e0 != D + 2) begin errors++; $display("FAIL short_latency got=%0d exp=%0d", pc - e0, D + 2); end
        checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL short_mode got=%0d exp=1", bus.mode); end
    endtask

    task automatic test_glitch();
        int n0 = 0, nl0 = 0;
        stim.delete();
        add(3'b111, 3);
        repeat (3) begin add(3'b110, 2); add(3'b111, int'($urandom_range(1, 3))); end
        add(3'b110, 6);
        repeat (3) begin add(3'b111, int'($urandom_range(1, 2))); add(3'b110, 2); end
        add(3'b111, 15);
        foreach (stim[i]) begin
            bus.btn = stim[i]; step();
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL glitch cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); end
            if (bus.press[0]) n0++;
            if (bus.long_p[0]) nl0++;
        end
        checks++; if (n0 != 1) begin errors++; $display("FAIL glitch_press got=%0d exp=1", n0); end
        checks++; if (nl0 != 0) begin errors++; $display("FAIL glitch_long got=%0d exp=0", nl0); end
        checks++; if (bus.mode !== 2'd2) begin errors++; $display("FAIL glitch_mode got=%0d exp=2", bus.mode); end
    endtask

    task automatic test_long();
        int e0 = 0, lc = -100, n0 = 0, nl0 = 0;
        checks++; if (bus.mode !== 2'd2) begin errors++; $display("FAIL long_start_mode got=%0d exp=2", bus.mode); end
        stim.delete();
        add(3'b110, 40); add(3'b111, 15);
        foreach (stim[i]) begin
            bus.btn = stim[i]; step();
            if (i == 0) e0 = cyc;
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL long cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); end
            if (bus.press[0]) n0++;
            if (bus.long_p[0]) begin nl0++; lc = cyc; end
        end
        checks++; if (nl0 != 1) begin errors++; $display("FAIL long_count got=%0d exp=1", nl0); end
        checks++; if (n0 != 0) begin errors++; $display("FAIL long_press got=%0d exp=0", n0); end
        checks++; if (lc - e0 != D + L + 3) begin errors++; $display("FAIL long_latency got=%0d exp=%0d", lc - e0, D + L + 3); end
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL long_mode got=%0d exp=0", bus.mode); end
    endtask

    task automatic test_wrap();
        int got[$];
        int want[5] = '{3, 0, 1, 2, 3};
        stim.delete();
        add(3'b101, 8); add(3'b111, 10);
        repeat (4) begin add(3'b110, 8); add(3'b111, 10); end
        foreach (stim[i]) begin
            bus.btn = stim[i]; step();
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); end
            if (bus.mode_chg) got.push_back(int'(bus.mode));
        end
        checks++;
        if (got.size() != 5) begin
            errors++; $display("FAIL wrap_chg_count got=%0d exp=5", got.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (got[k] != want[k]) begin errors++; $display("FAIL wrap_seq idx=%0d got=%0d exp=%0d", k, got[k], want[k]); end
            end
        end
    endtask

    task automatic test_simul();
        int nchg = 0, nboth = 0, n2 = 0, nl = 0;
        stim.delete();
        add(3'b100, 8); add(3'b111, 12); add(3'b011, 8); add(3'b111, 12);
        foreach (stim[i]) begin
            bus.btn = stim[i]; step();
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL simul cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); end
            if (bus.mode_chg) nchg++;
            if (bus.press[1:0] == 2'b11) nboth++;
            if (bus.press[2]) n2++;
            if (bus.long_p != '0) nl++;
        end
        checks++; if (nboth != 1) begin errors++; $display("FAIL simul_both got=%0d exp=1", nboth); end
        checks++; if (nchg != 0) begin errors++; $display("FAIL simul_chg got=%0d exp=0", nchg); end
        checks++; if (n2 != 1) begin errors++; $display("FAIL simul_btn2 got=%0d exp=1", n2); end
        checks++; if (nl != 0) begin errors++; $display("FAIL simul_long got=%0d exp=0", nl); end
        checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL simul_mode got=%0d exp=3", bus.mode); end
    endtask

    task automatic test_reset_mid();
        int early = 0, n0 = 0;
        stim.delete();
        add(3'b110, 10);
        foreach (stim[i]) begin
            bus.btn = stim[i]; step();
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL rstmid_pre cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 9'h0) begin errors++; $display("FAIL rstmid_async got=%h exp=000", dut_vec); end
        #4 rst_n = 1'b1;
        model_reset();
        stim.delete();
        add(3'b110, 10); add(3'b111, 15);
        foreach (stim[i]) begin
            bus.btn = stim[i]; step();
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL rstmid_post cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); end
            if (bus.press[0]) begin n0++; if (i < 10) early++; end
        end
        checks++; if (early != 0) begin errors++; $display("FAIL rstmid_early got=%0d exp=0", early); end
        checks++; if (n0 != 1) begin errors++; $display("FAIL rstmid_press got=%0d exp=1", n0); end
        checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL rstmid_mode got=%0d exp=1", bus.mode); end
    endtask

    task automatic test_random();
        stim.delete();
        repeat (40) add(NB'($urandom_range(0, 7)), int'($urandom_range(1, 30)));
        add(3'b111, 30);
        foreach (stim[i]) begin
            bus.btn = stim[i]; step();
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); end
        end
    endtask

    initial begin
        bus.btn = '1;
        rst_n   = 1'b0;
        model_reset();
        test_reset();
        test_short();
        test_glitch();
        test_long();
        test_wrap();
        test_simul();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_mode_ctrl.md
BTN_MODE_CTRL -- requirements
Module: btn_mode_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_BTN, default 2, the number of active-low push-buttons (minimum 2).
REQ-002 The block SHALL have parameter DEBOUNCE_CYC, default 50000, the consecutive stable cycles required to accept a level change (minimum 2).
REQ-003 The block SHALL have parameter LONG_CYC, default 25000000, the debounced-hold cycles that qualify a long press (must exceed DEBOUNCE_CYC).
REQ-004 The block SHALL have parameter NUM_MODE, default 4, the waveform mode count (minimum 2); MODE_W = $clog2(NUM_MODE).
REQ-005 The block SHALL have port Ext_CLK, input, 1 bit: the single system clock.
REQ-006 The block SHALL have port Ext_RESETn, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port iExtBtn, input, NUM_BTN bits: raw asynchronous buttons, 0 = pressed.
REQ-008 The block SHALL have port oPress, output, NUM_BTN bits: one-cycle short-press pulse per button.
REQ-009 The block SHALL have port oLong, output, NUM_BTN bits: one-cycle long-press pulse per button.
REQ-010 The block SHALL have port oMode, output, MODE_W bits: current waveform mode.
REQ-011 The block SHALL have port oModeChg, output, 1 bit: one-cycle pulse coincident with each oMode update.

Function
REQ-012 Each iExtBtn bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-013 Per button, the debounced level SHALL change only after the synchronised level has differed from it for DEBOUNCE_CYC consecutive cycles; any reversion clears the count.
REQ-014 Per-button FSM states SHALL be IDLE, PRESSED and LONG.
- IDLE -> PRESSED on a debounced press; hold counter cleared.
- PRESSED -> LONG when the hold counter reaches LONG_CYC; oLong pulses once.
- PRESSED -> IDLE on a debounced release; oPress pulses once.
- LONG -> IDLE on a debounced release; no pulse.
REQ-015 A bounce-free raw release SHALL produce oPress exactly 2+DEBOUNCE_CYC cycles after the first clock edge that samples the new raw level.
REQ-016 The hold counter SHALL saturate at LONG_CYC and SHALL NOT wrap.
REQ-017 A btn0 short press SHALL increment oMode, wrapping NUM_MODE-1 -> 0.
REQ-018 A btn1 short press SHALL decrement oMode, wrapping 0 -> NUM_MODE-1.
REQ-019 A btn0 long press SHALL load oMode = 0.
REQ-020 oMode SHALL update one cycle after the causing pulse, with oModeChg high in that same cycle.
REQ-021 Simultaneous events in one cycle SHALL resolve as follows:
- Increment and decrement together: no change and no oModeChg.
- Long press with any other event: long press wins.
REQ-022 Buttons at index 2 and above SHALL produce oPress/oLong only and SHALL NOT affect oMode.
REQ-023 A long press on btn0 while oMode is already 0 SHALL still pulse oModeChg.

Reset
REQ-024 While Ext_RESETn = 0, the block SHALL hold:
- oPress, oLong, oModeChg = 0; oMode = 0.
- All counters = 0; all FSMs in IDLE.
- Synchronisers and debounced levels = 1 (released).
REQ-025 A button held through reset release SHALL be treated as a new press requiring full debounce, with no pulse for the pre-reset press.

Structure
REQ-026 Package dds_ui_pkg SHALL hold the FSM state typedef and the default parameter constants.
REQ-027 Per-button synchroniser, debounce and FSM logic SHALL live in sub-module btn_debounce, instantiated NUM_BTN times via generate; mode logic SHALL stay at top level.

Verification (DEBOUNCE_CYC=4, LONG_CYC=20, NUM_MODE=4, NUM_BTN=3, 10 ns clock)
REQ-028 The bench SHALL cover these scenarios:
- btn0 low 100 ns, then high -> one oPress[0]; oMode 0->1 with oModeChg; latency per REQ-015.
- btn0 glitches low 20 ns three times during press and release -> exactly one oPress[0], no oLong.
- btn1 short press with oMode=0 -> oMode=3; four btn0 presses from 3 -> 0,1,2,3.
- btn0 held 400 ns with oMode=2 -> oLong[0] once at hold count 20; oMode=0; no oPress on release.
- btn0 and btn1 released in the same cycle -> oMode unchanged, oModeChg=0; btn2 press -> oPress[2] only.
- Ext_RESETn pulsed low 5 ns mid-press -> all outputs 0 immediately; after release with btn still held, no pulse until new debounce and release.
